// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode encodings, instruction length decode and the
// fetch state enum, reused by the fetch sequencer and the execution unit.
package cpu_pkg;

    localparam logic [7:0] OP_NOP     = 8'h00;
    localparam logic [7:0] OP_MOV_RA  = 8'h04;
    localparam logic [7:0] OP_MOV_IR  = 8'h06;
    localparam logic [7:0] OP_ADD     = 8'h08;
    localparam logic [7:0] OP_JMP     = 8'h0A;
    localparam logic [7:0] OP_AND     = 8'h0C;
    localparam logic [7:0] OP_CLR     = 8'h0E;
    localparam logic [7:0] OP_LSHIFT  = 8'h10;

    typedef enum logic [1:0] {
        FETCH_OP  = 2'd0,
        FETCH_OP1 = 2'd1,
        FETCH_OP2 = 2'd2,
        ISSUE     = 2'd3
    } fetch_state_e;

    // Unknown opcodes are treated as single-byte instructions.
    function automatic logic [1:0] instr_len(input logic [7:0] op);
        case (op)
            OP_MOV_RA, OP_MOV_IR, OP_ADD, OP_AND: instr_len = 2'd3;
            OP_JMP, OP_CLR, OP_LSHIFT:            instr_len = 2'd2;
            default:                              instr_len = 2'd1;
        endcase
    endfunction

    function automatic logic op_legal(input logic [7:0] op);
        case (op)
            OP_NOP, OP_MOV_RA, OP_MOV_IR, OP_ADD,
            OP_JMP, OP_AND, OP_CLR, OP_LSHIFT: op_legal = 1'b1;
            default:                           op_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/fetch_sequencer.sv
// Byte-serial instruction fetch: assembles 1-3 byte instructions from program
// memory and presents them to the execution unit with a valid/ready handshake.
module fetch_sequencer
    import cpu_pkg::*;
#(
    parameter logic [7:0] RESET_PC = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    output logic [7:0] pm_addr,
    input  logic [7:0] pm_data,
    output logic       instr_valid,
    input  logic       instr_ready,
    output logic [7:0] instr_opcode,
    output logic [7:0] instr_op1,
    output logic [7:0] instr_op2,
    output logic [7:0] instr_pc,
    output logic       instr_illegal,
    input  logic       jmp_valid,
    input  logic [7:0] jmp_target
);

    fetch_state_e state_q, state_d;
    logic [7:0]   pc_q, pc_d;
    logic [7:0]   opcode_q, opcode_d;
    logic [7:0]   op1_q, op1_d;
    logic [7:0]   op2_q, op2_d;
    logic [7:0]   ipc_q, ipc_d;
    logic         illegal_q, illegal_d;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        opcode_d  = opcode_q;
        op1_d     = op1_q;
        op2_d     = op2_q;
        ipc_d     = ipc_q;
        illegal_d = illegal_q;

        case (state_q)
            FETCH_OP: begin
                opcode_d  = pm_data;
                ipc_d     = pc_q;
                op1_d     = '0;
                op2_d     = '0;
                illegal_d = ~op_legal(pm_data);
                pc_d      = pc_q + 8'd1;
                state_d   = (instr_len(pm_data) >= 2'd2) ? FETCH_OP1 : ISSUE;
            end
            FETCH_OP1: begin
                op1_d   = pm_data;
                pc_d    = pc_q + 8'd1;
                state_d = (instr_len(opcode_q) == 2'd3) ? FETCH_OP2 : ISSUE;
            end
            FETCH_OP2: begin
                op2_d   = pm_data;
                pc_d    = pc_q + 8'd1;
                state_d = ISSUE;
            end
            ISSUE: begin
                if (instr_ready) begin
                    state_d = FETCH_OP;
                end
            end
            default: state_d = FETCH_OP;
        endcase

        // A redirect overrides any fetch progress; a handshake in the same
        // cycle still counts as consumed since valid/ready were both high.
        if (jmp_valid) begin
            pc_d    = jmp_target;
            state_d = FETCH_OP;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= FETCH_OP;
            pc_q      <= RESET_PC;
            opcode_q  <= '0;
            op1_q     <= '0;
            op2_q     <= '0;
            ipc_q     <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            opcode_q  <= opcode_d;
            op1_q     <= op1_d;
            op2_q     <= op2_d;
            ipc_q     <= ipc_d;
            illegal_q <= illegal_d;
        end
    end

    assign pm_addr       = pc_q;
    assign instr_valid   = (state_q == ISSUE);
    assign instr_opcode  = opcode_q;
    assign instr_op1     = op1_q;
    assign instr_op2     = op2_q;
    assign instr_pc      = ipc_q;
    assign instr_illegal = illegal_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: expected instructions are queued per
// scenario and retired against every valid/ready handshake.
module tb_fetch_sequencer;

    localparam logic [7:0] RST_PC = 8'h00;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] pm_addr;
    logic [7:0] pm_data;
    logic       instr_valid;
    logic       instr_ready;
    logic [7:0] instr_opcode;
    logic [7:0] instr_op1;
    logic [7:0] instr_op2;
    logic [7:0] instr_pc;
    logic       instr_illegal;
    logic       jmp_valid;
    logic [7:0] jmp_target;

    logic [7:0] mem [256];

    typedef struct packed {
        logic [7:0] opc;
        logic [7:0] op1;
        logic [7:0] op2;
        logic [7:0] pc;
        logic       ill;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    assign pm_data = mem[pm_addr];

    fetch_sequencer #(.RESET_PC(RST_PC)) dut (
        .clk          (clk),
        .rst          (rst),
        .pm_addr      (pm_addr),
        .pm_data      (pm_data),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .instr_opcode (instr_opcode),
        .instr_op1    (instr_op1),
        .instr_op2    (instr_op2),
        .instr_pc     (instr_pc),
        .instr_illegal(instr_illegal),
        .jmp_valid    (jmp_valid),
        .jmp_target   (jmp_target)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input logic [7:0] opc, input logic [7:0] op1,
                            input logic [7:0] op2, input logic [7:0] pc, input logic ill);
        exp_t e;
        e.opc = opc; e.op1 = op1; e.op2 = op2; e.pc = pc; e.ill = ill;
        exp_q.push_back(e);
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    endtask

    // Holds reset, checks the reset-state outputs, then releases just after a rising edge.
    task automatic reset_dut();
        rst = 1'b1;
        jmp_valid = 1'b0;
        jmp_target = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_pm_addr", pm_addr, RST_PC);
        chk("rst_valid", instr_valid, 0);
        chk("rst_opcode", instr_opcode, 0);
        chk("rst_op1", instr_op1, 0);
        chk("rst_op2", instr_op2, 0);
        chk("rst_pc", instr_pc, 0);
        chk("rst_illegal", instr_illegal, 0);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic jump_to(input logic [7:0] t);
        jmp_valid = 1'b1;
        jmp_target = t;
        @(posedge clk);
        #1 jmp_valid = 1'b0;
    endtask

    // Retires handshakes against the queue; returns on the negedge of the last one.
    task automatic drain(input int budget);
        exp_t e;
        for (int c = 0; c < budget && exp_q.size() > 0; c++) begin
            @(negedge clk);
            if (instr_valid && instr_ready) begin
                e = exp_q.pop_front();
                chk("issue_opcode", instr_opcode, e.opc);
                chk("issue_op1", instr_op1, e.op1);
                chk("issue_op2", instr_op2, e.op2);
                chk("issue_pc", instr_pc, e.pc);
                chk("issue_illegal", instr_illegal, e.ill);
            end
        end
        if (exp_q.size() != 0) begin
            chk("drain_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        rst = 1'b1;
        instr_ready = 1'b1;
        jmp_valid = 1'b0;
        jmp_target = 8'h00;

        // Basic sequence of 1- and 3-byte instructions.
        clear_mem();
        mem[0] = 8'h00; mem[1] = 8'h06; mem[2] = 8'h50; mem[3] = 8'h02;
        mem[4] = 8'h04; mem[5] = 8'h02; mem[6] = 8'hD0;
        reset_dut();
        push_exp(8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
        push_exp(8'h06, 8'h50, 8'h02, 8'h01, 1'b0);
        push_exp(8'h04, 8'h02, 8'hD0, 8'h04, 1'b0);
        drain(30);
        @(posedge clk);
        @(negedge clk);
        chk("seq_next_pm_addr", pm_addr, 8'h07);
        chk("seq_next_valid", instr_valid, 0);

        // Backpressure: instruction held stable while ready is low.
        reset_dut();
        instr_ready = 1'b1;
        push_exp(8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
        drain(10);
        @(posedge clk);
        #1 instr_ready = 1'b0;
        seen = 0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            seen = instr_valid;
        end
        chk("hold_valid_seen", seen, 1);
        for (int c = 0; c < 5; c++) begin
            if (c > 0) @(negedge clk);
            chk("hold_valid", instr_valid, 1);
            chk("hold_opcode", instr_opcode, 8'h06);
            chk("hold_op1", instr_op1, 8'h50);
            chk("hold_op2", instr_op2, 8'h02);
            chk("hold_pc", instr_pc, 8'h01);
            chk("hold_pm_addr", pm_addr, 8'h04);
        end
        @(posedge clk);
        #1 instr_ready = 1'b1;
        push_exp(8'h06, 8'h50, 8'h02, 8'h01, 1'b0);
        drain(10);

        // Redirect during FETCH_OP1 drops the partial instruction.
        clear_mem();
        mem[8'h00] = 8'h06; mem[8'h01] = 8'h11; mem[8'h02] = 8'h22;
        mem[8'h20] = 8'h0E; mem[8'h21] = 8'h33;
        reset_dut();
        @(posedge clk);
        #1 jump_to(8'h20);
        @(negedge clk);
        chk("jmp_pm_addr", pm_addr, 8'h20);
        chk("jmp_valid_drop", instr_valid, 0);
        push_exp(8'h0E, 8'h33, 8'h00, 8'h20, 1'b0);
        drain(20);
        // Redirect coinciding with a handshake: instruction consumed, jump taken.
        jmp_valid = 1'b1;
        jmp_target = 8'h40;
        @(posedge clk);
        #1 jmp_valid = 1'b0;
        @(negedge clk);
        chk("jmp_hs_pm_addr", pm_addr, 8'h40);
        chk("jmp_hs_valid", instr_valid, 0);
        push_exp(8'h00, 8'h00, 8'h00, 8'h40, 1'b0);
        drain(10);

        // Illegal opcode, operands cleared after a 2-byte instruction.
        clear_mem();
        mem[8'h0E] = 8'h0A; mem[8'h0F] = 8'h55; mem[8'h10] = 8'h77;
        reset_dut();
        jump_to(8'h0E);
        push_exp(8'h0A, 8'h55, 8'h00, 8'h0E, 1'b0);
        push_exp(8'h77, 8'h00, 8'h00, 8'h10, 1'b1);
        push_exp(8'h00, 8'h00, 8'h00, 8'h11, 1'b0);
        drain(30);

        // Instruction straddling the PC wrap.
        clear_mem();
        mem[8'hFE] = 8'h06; mem[8'hFF] = 8'hAA; mem[8'h00] = 8'h03;
        reset_dut();
        jump_to(8'hFE);
        push_exp(8'h06, 8'hAA, 8'h03, 8'hFE, 1'b0);
        push_exp(8'h00, 8'h00, 8'h00, 8'h01, 1'b0);
        drain(30);

        // Reset in FETCH_OP2 restarts from RESET_PC.
        clear_mem();
        mem[8'h00] = 8'h08; mem[8'h01] = 8'h01; mem[8'h02] = 8'h02;
        reset_dut();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst_valid", instr_valid, 0);
        chk("midrst_pm_addr", pm_addr, RST_PC);
        push_exp(8'h08, 8'h01, 8'h02, 8'h00, 1'b0);
        push_exp(8'h00, 8'h00, 8'h00, 8'h03, 1'b0);
        drain(30);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
